// File: rtl/credit_pool_cntr.sv
// credit_pool_cntr
//   Multi-channel credit manager. Each channel holds a loadable budget
//   (max) and a live credit count (cnt). Returned credits refill the count
//   up to max; a refill to a full channel is dropped and flagged sticky in
//   err_ovf. Every cycle at most one requesting channel with credit is
//   granted, round-robin starting from ptr, and that grant consumes one
//   credit at the next edge.
//
// Ports
//   clk          rising-edge clock
//   rst_b        asynchronous active-low reset
//   cfg_load     load cfg_credits into max/cnt of channel cfg_ch
//   cfg_ch       channel to load; out-of-range values ignore the load
//   cfg_credits  new budget and current credit for cfg_ch
//   credit_ret   one returned credit per set bit
//   req          per-channel send request
//   err_clr      clears every sticky err_ovf bit
//   gnt          combinational one-hot-or-zero grant
//   credit_cnt   live credit counts, channel i at [i*BW +: BW]
//   no_credits   cnt[i] == 0
//   low_credits  cnt[i] <= LOW_WM
//   err_ovf      sticky: a credit return to a full channel was dropped
module credit_pool_cntr #(
  parameter int NUM_CH = 4,
  parameter int BW     = 4,
  parameter int LOW_WM = 1,
  localparam int CHW   = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 cfg_load,
  input  logic [CHW-1:0]       cfg_ch,
  input  logic [BW-1:0]        cfg_credits,
  input  logic [NUM_CH-1:0]    credit_ret,
  input  logic [NUM_CH-1:0]    req,
  input  logic                 err_clr,
  output logic [NUM_CH-1:0]    gnt,
  output logic [NUM_CH*BW-1:0] credit_cnt,
  output logic [NUM_CH-1:0]    no_credits,
  output logic [NUM_CH-1:0]    low_credits,
  output logic [NUM_CH-1:0]    err_ovf
);

  localparam int unsigned      NCH   = NUM_CH;
  localparam logic [BW-1:0]    LOW_V = BW'(LOW_WM);

  logic [NUM_CH-1:0][BW-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0][BW-1:0] max_q, max_d;
  logic [CHW-1:0]            ptr_q, ptr_d;
  logic [NUM_CH-1:0]         err_q, err_d;

  logic [NUM_CH-1:0]         ld_sel;
  logic [NUM_CH-1:0]         elig;
  logic [NUM_CH-1:0]         gnt_c;
  logic [NUM_CH-1:0]         ovf;

  // Per-channel load decode; an out-of-range cfg_ch matches no channel.
  always_comb begin
    ld_sel = '0;
    elig   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      ld_sel[i] = cfg_load && (cfg_ch == CHW'(i));
      elig[i]   = req[i] && (cnt_q[i] != '0) && !ld_sel[i];
    end
  end

  // Round-robin search from ptr; the pointer moves just past the winner.
  always_comb begin
    int unsigned idx;
    int unsigned nxt;
    logic [CHW-1:0] sel;
    logic found;
    gnt_c = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    nxt   = 0;
    sel   = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      sel = CHW'(idx);
      if (!found && elig[sel]) begin
        found      = 1'b1;
        gnt_c[sel] = 1'b1;
        nxt        = idx + 1;
        if (nxt == NCH) nxt = 0;
        ptr_d      = CHW'(nxt);
      end
    end
  end

  // Grant and return in the same cycle cancel, so a full channel can take
  // a return alongside its own grant without flagging an overflow.
  always_comb begin
    cnt_d = cnt_q;
    max_d = max_q;
    ovf   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (ld_sel[i]) begin
        max_d[i] = cfg_credits;
        cnt_d[i] = cfg_credits;
      end else if (gnt_c[i] && !credit_ret[i]) begin
        cnt_d[i] = cnt_q[i] - BW'(1);
      end else if (!gnt_c[i] && credit_ret[i]) begin
        if (cnt_q[i] < max_q[i]) begin
          cnt_d[i] = cnt_q[i] + BW'(1);
        end else begin
          ovf[i] = 1'b1;
        end
      end
    end
    // A fresh overflow wins over a same-cycle clear.
    err_d = (err_q & ~{NUM_CH{err_clr}}) | ovf;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q <= '0;
      max_q <= '0;
      ptr_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      max_q <= max_d;
      ptr_q <= ptr_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    no_credits  = '0;
    low_credits = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      no_credits[i]  = (cnt_q[i] == '0);
      low_credits[i] = (cnt_q[i] <= LOW_V);
    end
  end

  assign gnt        = gnt_c;
  assign credit_cnt = cnt_q;
  assign err_ovf    = err_q;

endmodule

// File: doc/credit_pool_cntr.md
# credit_pool_cntr

Multi-channel credit manager generalising the team's single-channel credit counter. It tracks a loadable credit budget per channel, accepts returned credits, and arbitrates round-robin among requesting channels. Each cycle it grants at most one channel that holds a credit, and that grant consumes one credit. It sits between the upstream per-channel senders and a shared downstream link with per-channel buffering.

## Interface
- NUM_CH, 4, number of channels (≥2); CHW = $clog2(NUM_CH)
- BW, 4, credit counter width per channel
- LOW_WM, 1, low-watermark threshold (< 2^BW)

- clk  in  1  clock, rising edge
- rst_b  in  1  reset, asynchronous, active-low
- cfg_load  in  1  load budget for channel cfg_ch this cycle
- cfg_ch  in  CHW  channel to load; values ≥ NUM_CH ignore the load
- cfg_credits  in  BW  new max and current credit for cfg_ch
- credit_ret  in  NUM_CH  one credit returned per set bit
- req  in  NUM_CH  channel wants to send one unit
- err_clr  in  1  clears all sticky error bits
- gnt  out  NUM_CH  combinational one-hot-or-zero grant; consumes one credit at the next edge
- credit_cnt  out  NUM_CH*BW  current credits, channel i at [i*BW +: BW]
- no_credits  out  NUM_CH  cnt[i] == 0
- low_credits  out  NUM_CH  cnt[i] ≤ LOW_WM
- err_ovf  out  NUM_CH  sticky: a credit return was dropped

## Operation
- Per-channel state: max[i], cnt[i] (BW bits each); a shared round-robin pointer ptr (CHW bits); err_ovf[i].
- Channel i is eligible when req[i] is high, cnt[i] != 0, and channel i is not being loaded this cycle.
- Arbitration searches ptr, ptr+1, … modulo NUM_CH. The first eligible channel is granted.
- After a grant to channel k, ptr ← (k+1) mod NUM_CH. When nothing is granted, ptr holds.
- Counter update for each channel not being loaded, with g = gnt[i] and r = credit_ret[i]:
  - g & !r: cnt − 1 (never underflows, since g requires cnt != 0).
  - !g & r & cnt < max: cnt + 1.
  - !g & r & cnt == max: return dropped, cnt holds, err_ovf[i] set.
  - g & r: cnt holds, no error, even when cnt == max.
  - neither: hold.
- Load: when cfg_load is high and cfg_ch < NUM_CH, max[cfg_ch] and cnt[cfg_ch] ← cfg_credits. The load overrides the same-cycle credit_ret for that channel, with no error raised. gnt[cfg_ch] is forced to 0 that cycle. Other channels are unaffected.
- A channel with max == 0 is disabled. Its cnt stays 0 and it is never granted. Any return to it sets err_ovf (cnt == max rule).
- Loading 0 disables a channel; loading a nonzero value re-enables it.
- err_ovf[i] clears on err_clr. A new overflow in the same cycle as err_clr wins, so the bit stays set.
- Arithmetic is unsigned BW-bit. cnt never wraps in either direction.

## Timing
- Reset (rst_b low, asynchronous): cnt, max, ptr, and err_ovf all go to 0.
  - Reset outputs: gnt = 0, credit_cnt = 0, no_credits = all 1, low_credits = all 1, err_ovf = 0.
- gnt is combinational from req, cnt, ptr, cfg_load, and cfg_ch in the same cycle. Grant-to-decrement latency is 1 edge.
- credit_ret and cfg_load take effect at the next rising edge. Status outputs are combinational from registered state, so they reflect a change in the cycle after the edge.
- A credit freed by credit_ret in cycle N is grantable in cycle N+1, never in cycle N.
- Reset asserted mid-operation discards all budgets. Software must reload every channel after reset.

## Test plan
- Reset → gnt = 0, no_credits = 4'b1111, low_credits = 4'b1111, err_ovf = 0. Load ch2 = 3 → credit_cnt[ch2] = 3 next cycle, low_credits[2] = 0.
- Load every channel with 2, hold req = 4'b1111 for 8 cycles → grant order 0, 1, 2, 3, 0, 1, 2, 3, then gnt = 0 and no_credits = 4'b1111.
- ch1 max = 2 and cnt = 2:
  - credit_ret[1] → err_ovf[1] = 1, cnt stays 2.
  - credit_ret[1] together with gnt[1] → cnt stays 2, no new error.
  - err_clr plus a new overflow in the same cycle → err_ovf[1] remains 1.
- ch0 cnt = 0, req[0] and credit_ret[0] in cycle N → gnt[0] = 0 in N, cnt = 1 and gnt[0] = 1 in N+1.
- cfg_load ch3 = 5 while req[3] = 1, cnt[3] = 1, and credit_ret[3] = 1 → gnt[3] = 0 that cycle, cnt[3] = 5 next.
- Load ch0 = 0 while it holds credits → cnt = 0, never granted; a later credit_ret[0] sets err_ovf[0]. cfg_ch ≥ NUM_CH load → no state change.
